// File: rtl/full_st0_tap_ctrl_pkg.sv
// Shared types for the stage-0 tap memory control path: the tap_int_192_4
// control bundle, the controller state encoding and the array geometry.
package full_st0_tap_ctrl_pkg;

  localparam int TAP_LANES  = 6;
  localparam int TAP_ROWS   = 16;
  localparam int TAP_AW     = 4;
  localparam int TAP_LW     = 3;
  localparam int TAP_WORD_W = 32;
  localparam int TAP_ROW_W  = TAP_LANES * TAP_WORD_W;

  // Controller states; IDLE must stay the all-zero code so reset is trivial.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } tap_ctrl_state_e;

  // Control bundle seen by the tap memory (4-bit row address variant).
  typedef struct packed {
    logic                  wr_vld;
    logic [TAP_AW-1:0]     wr_address;
    logic                  sub_vld;
    logic [TAP_LW-1:0]     sub_addr;
    logic [TAP_WORD_W-1:0] sub_data;
    logic                  rd_vld;
    logic [TAP_AW-1:0]     rd_address;
    logic                  inter;
    logic                  inter_first;
  } tap_int_192_4;

  // True when a (row, lane) position is the final slot of a rows x lanes walk.
  function automatic logic is_last_slot(input logic [TAP_AW-1:0] row,
                                        input logic [TAP_LW-1:0] lane,
                                        input logic [TAP_AW-1:0] last_row,
                                        input logic [TAP_LW-1:0] last_lane);
    return (row == last_row) && (lane == last_lane);
  endfunction

endpackage

// File: rtl/full_st0_tap_rd_align.sv
// Return-path alignment: delays the issued read valid/last flags by the tap
// memory read latency, then registers them together with the returned row.
module full_st0_tap_rd_align #(
  parameter int RD_LAT = 1,
  parameter int DW     = 192
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_vld_i,
  input  logic          issue_last_i,
  input  logic [DW-1:0] rd_data_i,
  output logic          row_vld_o,
  output logic          row_last_o,
  output logic [DW-1:0] row_data_o
);

  logic [RD_LAT-1:0] vld_pipe_q;
  logic [RD_LAT-1:0] vld_pipe_d;
  logic [RD_LAT-1:0] last_pipe_q;
  logic [RD_LAT-1:0] last_pipe_d;
  logic              row_vld_q;
  logic              row_vld_d;
  logic              row_last_q;
  logic              row_last_d;
  logic [DW-1:0]     row_data_q;
  logic [DW-1:0]     row_data_d;

  // Shift the issue flags one stage per cycle; stage RD_LAT-1 lines up with rd_data_i.
  always_comb begin
    vld_pipe_d     = vld_pipe_q;
    last_pipe_d    = last_pipe_q;
    vld_pipe_d[0]  = issue_vld_i;
    last_pipe_d[0] = issue_vld_i & issue_last_i;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      last_pipe_d[i] = last_pipe_q[i-1];
    end
  end

  // Output stage: capture the row only when the memory is returning a requested row.
  always_comb begin
    row_vld_d  = vld_pipe_q[RD_LAT-1];
    row_last_d = last_pipe_q[RD_LAT-1];
    if (vld_pipe_q[RD_LAT-1]) begin
      row_data_d = rd_data_i;
    end else begin
      row_data_d = row_data_q;
    end
  end

  // Registers with synchronous active-low reset; reset also flushes in-flight reads.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      row_vld_q   <= 1'b0;
      row_last_q  <= 1'b0;
      row_data_q  <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      row_vld_q   <= row_vld_d;
      row_last_q  <= row_last_d;
      row_data_q  <= row_data_d;
    end
  end

  assign row_vld_o  = row_vld_q;
  assign row_last_o = row_last_q;
  assign row_data_o = row_data_q;

endmodule

// File: rtl/full_st0_tap_ctrl.sv
// Stage-0 tap memory controller: packs a serial word stream into per-lane
// sub-writes (LOAD) and sequences linear or interleaved row reads (READ),
// owning every row/lane counter so the memory itself stays address-driven.
module full_st0_tap_ctrl
  import full_st0_tap_ctrl_pkg::*;
#(
  parameter int LANES  = TAP_LANES,
  parameter int ROWS   = TAP_ROWS,
  parameter int AW     = TAP_AW,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_load,
  input  logic                  start_read,
  input  logic                  read_inter,
  input  logic                  load_vld,
  input  logic [31:0]           load_data,
  output logic                  load_ready,
  output tap_int_192_4          tap_int,
  output logic [LANES*32-1:0]   tap_int_wr_data,
  input  logic [LANES*32-1:0]   tap_int_rd_data,
  output logic                  row_vld,
  output logic [LANES*32-1:0]   row_data,
  output logic                  row_last,
  output logic                  busy,
  output logic                  done
);

  localparam int LW = TAP_LW;
  localparam int DCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [AW-1:0]  LAST_ROW  = AW'(ROWS - 1);
  localparam logic [LW-1:0]  LAST_LANE = LW'(LANES - 1);
  localparam logic [DCW-1:0] LAST_WAIT = DCW'(RD_LAT - 1);

  tap_ctrl_state_e state_q;
  tap_ctrl_state_e state_d;
  logic [AW-1:0]   row_q;
  logic [AW-1:0]   row_d;
  logic [LW-1:0]   lane_q;
  logic [LW-1:0]   lane_d;
  logic [DCW-1:0]  wait_q;
  logic [DCW-1:0]  wait_d;
  logic            inter_q;
  logic            inter_d;
  logic            done_q;
  logic            done_d;

  tap_int_192_4    tap_int_s;
  logic            load_ready_s;
  logic            issue_last_s;

  // Next-state, counter stepping and the combinational control bundle.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    lane_d       = lane_q;
    wait_d       = wait_q;
    inter_d      = inter_q;
    done_d       = 1'b0;
    load_ready_s = 1'b0;
    issue_last_s = 1'b0;
    tap_int_s    = '0;

    case (state_q)
      IDLE: begin
        row_d  = '0;
        lane_d = '0;
        wait_d = '0;
        // LOAD has priority; a coincident start_read is simply dropped.
        if (start_load) begin
          state_d = LOAD;
        end else if (start_read) begin
          state_d = READ;
          inter_d = read_inter;
        end else begin
          state_d = IDLE;
        end
      end

      LOAD: begin
        load_ready_s = 1'b1;
        if (load_vld) begin
          tap_int_s.sub_vld    = 1'b1;
          tap_int_s.sub_addr   = lane_q;
          tap_int_s.sub_data   = load_data;
          tap_int_s.wr_address = row_q;
          if (is_last_slot(row_q, lane_q, LAST_ROW, LAST_LANE)) begin
            state_d = IDLE;
            row_d   = '0;
            lane_d  = '0;
            done_d  = 1'b1;
          end else if (lane_q == LAST_LANE) begin
            lane_d = '0;
            row_d  = row_q + AW'(1);
          end else begin
            lane_d = lane_q + LW'(1);
          end
        end else begin
          state_d = LOAD;
        end
      end

      READ: begin
        tap_int_s.rd_vld      = 1'b1;
        tap_int_s.rd_address  = row_q;
        tap_int_s.inter       = inter_q;
        // Beat 0 is the only beat with row 0, so it also restarts the memory's walk.
        tap_int_s.inter_first = inter_q && (row_q == '0);
        if (row_q == LAST_ROW) begin
          issue_last_s = 1'b1;
          state_d      = DRAIN;
          row_d        = '0;
        end else begin
          row_d = row_q + AW'(1);
        end
      end

      DRAIN: begin
        // Hold off completion until the final read has left the memory.
        if (wait_q == LAST_WAIT) begin
          state_d = IDLE;
          wait_d  = '0;
          done_d  = 1'b1;
        end else begin
          wait_d = wait_q + DCW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers; reset abandons any pass without a done pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      lane_q  <= '0;
      wait_q  <= '0;
      inter_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      lane_q  <= lane_d;
      wait_q  <= wait_d;
      inter_q <= inter_d;
      done_q  <= done_d;
    end
  end

  full_st0_tap_rd_align #(
    .RD_LAT (RD_LAT),
    .DW     (LANES*32)
  ) u_rd_align (
    .clk          (clk),
    .reset        (reset),
    .issue_vld_i  (tap_int_s.rd_vld),
    .issue_last_i (issue_last_s),
    .rd_data_i    (tap_int_rd_data),
    .row_vld_o    (row_vld),
    .row_last_o   (row_last),
    .row_data_o   (row_data)
  );

  assign tap_int         = tap_int_s;
  assign tap_int_wr_data = '0;
  assign load_ready      = load_ready_s;
  assign busy            = (state_q != IDLE);
  assign done            = done_q;

endmodule

// File: tb/tb_full_st0_tap_ctrl.sv
// Bench for full_st0_tap_ctrl: a per-cycle expectation timeline filled from
// the intended transaction behaviour, a behavioural tap memory driven by the
// DUT's control bundle, and a single compare process on the falling edge.
module tb_full_st0_tap_ctrl;
  import full_st0_tap_ctrl_pkg::*;

  localparam int MAXC = 4096;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_load, start_read, read_inter, load_vld;
  logic [31:0]  load_data;
  logic         load_ready;
  tap_int_192_4 tap_int;
  logic [191:0] tap_int_wr_data, tap_int_rd_data, row_data;
  logic         row_vld, row_last, busy, done;

  full_st0_tap_ctrl dut (
    .clk(clk), .reset(reset), .start_load(start_load), .start_read(start_read),
    .read_inter(read_inter), .load_vld(load_vld), .load_data(load_data),
    .load_ready(load_ready), .tap_int(tap_int), .tap_int_wr_data(tap_int_wr_data),
    .tap_int_rd_data(tap_int_rd_data), .row_vld(row_vld), .row_data(row_data),
    .row_last(row_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expectation timeline, indexed by cycle number.
  logic         e_ready[MAXC], e_busy[MAXC], e_done[MAXC];
  logic         e_sub_vld[MAXC], e_rd_vld[MAXC], e_inter[MAXC], e_ifirst[MAXC];
  logic [2:0]   e_sub_addr[MAXC];
  logic [3:0]   e_wr_addr[MAXC], e_rd_addr[MAXC];
  logic [31:0]  e_sub_data[MAXC];
  logic         e_row_vld[MAXC], e_row_last[MAXC];
  logic [191:0] e_row_data[MAXC];
  logic         e_pin[MAXC], e_mpin[MAXC];
  int           e_pin_lane[MAXC];
  logic [31:0]  e_pin_val[MAXC];

  logic [31:0]  w[96];          // reference: word i sits at row i/6, lane i%6
  bit           chk_on = 1'b0;
  int           n_chk = 0;
  int           n_err = 0;

  // Behavioural tap memory (RD_LAT=1) with its own interleave walk counters.
  logic [31:0]  mem[16][6];
  logic [191:0] rd_data_r = '0;
  int           ic = 0, ib = 0;
  assign tap_int_rd_data = rd_data_r;

  function automatic logic [191:0] mem_row_lin(input int r);
    logic [191:0] v;
    for (int l = 0; l < 6; l++) v[l*32 +: 32] = mem[r][l];
    return v;
  endfunction

  function automatic logic [191:0] mem_row_int(input int b, input int c);
    logic [191:0] v;
    for (int l = 0; l < 6; l++) v[l*32 +: 32] = mem[(b + (c + l) % 6) % 16][l];
    return v;
  endfunction

  always @(posedge clk) begin
    if (tap_int.sub_vld) mem[tap_int.wr_address][tap_int.sub_addr] <= tap_int.sub_data;
    if (tap_int.rd_vld) begin
      if (!tap_int.inter) begin
        rd_data_r <= mem_row_lin(int'(tap_int.rd_address));
      end else if (tap_int.inter_first) begin
        rd_data_r <= mem_row_int(int'(tap_int.rd_address), 0);
        ic <= 1;
        ib <= int'(tap_int.rd_address);
      end else begin
        rd_data_r <= mem_row_int(ib, ic);
        if (ic == 5) begin
          ic <= 0;
          ib <= ib + 6;
        end else begin
          ic <= ic + 1;
        end
      end
    end
  end

  // Reference row for beat k of a pass, straight from the transposition rule.
  function automatic logic [191:0] exp_row(input int k, input bit inter);
    logic [191:0] v;
    int r;
    for (int l = 0; l < 6; l++) begin
      r = inter ? (6 * (k / 6) + (k + l) % 6) % 16 : k;
      v[l*32 +: 32] = w[6*r + l];
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (chk_on && cyc < MAXC) begin
      logic [191:0] m;
      chk("load_ready", 192'(load_ready), 192'(e_ready[cyc]));
      chk("busy", 192'(busy), 192'(e_busy[cyc]));
      chk("done", 192'(done), 192'(e_done[cyc]));
      chk("wr_vld", 192'(tap_int.wr_vld), 192'(1'b0));
      chk("wr_data", tap_int_wr_data, 192'(0));
      chk("sub_vld", 192'(tap_int.sub_vld), 192'(e_sub_vld[cyc]));
      if (e_sub_vld[cyc]) begin
        chk("sub_addr", 192'(tap_int.sub_addr), 192'(e_sub_addr[cyc]));
        chk("wr_address", 192'(tap_int.wr_address), 192'(e_wr_addr[cyc]));
        chk("sub_data", 192'(tap_int.sub_data), 192'(e_sub_data[cyc]));
      end
      chk("rd_vld", 192'(tap_int.rd_vld), 192'(e_rd_vld[cyc]));
      chk("inter", 192'(tap_int.inter), 192'(e_inter[cyc]));
      chk("inter_first", 192'(tap_int.inter_first), 192'(e_ifirst[cyc]));
      if (e_rd_vld[cyc]) chk("rd_address", 192'(tap_int.rd_address), 192'(e_rd_addr[cyc]));
      chk("row_vld", 192'(row_vld), 192'(e_row_vld[cyc]));
      chk("row_last", 192'(row_last), 192'(e_row_last[cyc]));
      if (e_row_vld[cyc]) chk("row_data", row_data, e_row_data[cyc]);
      if (e_pin[cyc]) chk("row_pin", 192'(row_data[e_pin_lane[cyc]*32 +: 32]), 192'(e_pin_val[cyc]));
      if (e_mpin[cyc]) begin
        m = exp_row(2, 1'b0);
        chk("model_lin_r2l3", 192'(m[127:96]), 192'(32'h0000_010F));
        m = exp_row(7, 1'b1);
        chk("model_int_k7l0", 192'(m[31:0]), 192'(32'h0000_012A));
        chk("model_int_k7l5", 192'(m[191:160]), 192'(32'h0000_0129));
        m = exp_row(0, 1'b1);
        chk("model_int_k0l1", 192'(m[63:32]), 192'(32'h0000_0107));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    start_load = 1'b0;
    start_read = 1'b0;
    for (int i = 0; i < n; i++) begin
      load_vld  = 1'($urandom_range(0, 1));
      load_data = $urandom;
      tick();
    end
    load_vld = 1'b0;
  endtask

  // LOAD of 96 words; abort_at >= 0 pulls reset instead of that beat.
  task automatic do_load(input bit both, input int abort_at, input bit rnd);
    int k;
    logic [31:0] d;
    start_load = 1'b1;
    start_read = both;
    read_inter = 1'($urandom_range(0, 1));
    load_vld   = 1'b0;
    tick();
    start_load = 1'b0;
    start_read = 1'b0;
    k = 0;
    while (k < 96) begin
      e_ready[cyc] = 1'b1;
      e_busy[cyc]  = 1'b1;
      start_read = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
      start_load = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (k == abort_at) begin
        reset    = 1'b0;
        load_vld = 1'b0;
        tick();
        reset      = 1'b1;
        start_read = 1'b0;
        start_load = 1'b0;
        tick();
        return;
      end
      if (rnd && $urandom_range(0, 3) == 0) begin
        load_vld  = 1'b0;
        load_data = $urandom;
      end else begin
        d = rnd ? $urandom : (32'h0000_0100 + 32'(k));
        load_vld = 1'b1;
        load_data = d;
        w[k] = d;
        e_sub_vld[cyc]  = 1'b1;
        e_sub_addr[cyc] = 3'(k % 6);
        e_wr_addr[cyc]  = 4'(k / 6);
        e_sub_data[cyc] = d;
        k++;
      end
      tick();
    end
    load_vld   = 1'b0;
    start_read = 1'b0;
    start_load = 1'b0;
    e_done[cyc] = 1'b1;
    tick();
  endtask

  // READ pass of 16 rows; optional literal pin on beat 2's row data.
  task automatic do_read(input bit inter, input int pin_lane, input logic [31:0] pin_val);
    int c0;
    c0 = cyc;
    start_read = 1'b1;
    read_inter = inter;
    for (int k = 0; k < 16; k++) begin
      e_rd_vld[c0+1+k]   = 1'b1;
      e_rd_addr[c0+1+k]  = 4'(k);
      e_inter[c0+1+k]    = inter;
      e_ifirst[c0+1+k]   = inter && (k == 0);
      e_row_vld[c0+3+k]  = 1'b1;
      e_row_last[c0+3+k] = (k == 15);
      e_row_data[c0+3+k] = exp_row(k, inter);
    end
    for (int c = c0 + 1; c <= c0 + 17; c++) e_busy[c] = 1'b1;
    e_done[c0+18] = 1'b1;
    if (pin_lane >= 0) begin
      e_pin[c0+5]      = 1'b1;
      e_pin_lane[c0+5] = pin_lane;
      e_pin_val[c0+5]  = pin_val;
    end
    tick();
    start_read = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      read_inter = 1'($urandom_range(0, 1));
      load_vld   = 1'($urandom_range(0, 1));
      load_data  = $urandom;
      start_load = (i <= 16) && ($urandom_range(0, 5) == 0);
      start_read = (i <= 16) && ($urandom_range(0, 5) == 0);
      tick();
    end
    start_load = 1'b0;
    start_read = 1'b0;
    load_vld   = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < MAXC; c++) begin
      e_ready[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_sub_vld[c] = 0; e_rd_vld[c] = 0;
      e_inter[c] = 0; e_ifirst[c] = 0; e_sub_addr[c] = 0; e_wr_addr[c] = 0; e_rd_addr[c] = 0;
      e_sub_data[c] = 0; e_row_vld[c] = 0; e_row_last[c] = 0; e_row_data[c] = 0;
      e_pin[c] = 0; e_mpin[c] = 0; e_pin_lane[c] = 0; e_pin_val[c] = 0;
    end
    for (int i = 0; i < 96; i++) w[i] = 32'h0;
    reset = 1'b0; start_load = 1'b0; start_read = 1'b0; read_inter = 1'b0;
    load_vld = 1'b0; load_data = 32'h0;
    tick(); tick(); tick();
    reset  = 1'b1;
    chk_on = 1'b1;
    idle(2);

    // Deterministic load of 0x100+i, then pin the reference model itself.
    do_load(1'b0, -1, 1'b0);
    e_mpin[cyc] = 1'b1;
    idle(1);
    do_read(1'b0, 3, 32'h0000_010F);        // row 2 lane 3 = 0x100+15
    idle(2);
    do_read(1'b1, 0, 32'h0000_010C);        // beat 2 lane 0 comes from row 2
    idle(3);

    // Coincident starts: LOAD wins, random data with gaps and stray starts.
    do_load(1'b1, -1, 1'b1);
    idle(1);
    do_read(1'b1, -1, 32'h0);

    // Reset in place of beat 40, then a fresh load must restart at row 0 lane 0.
    idle(2);
    do_load(1'b0, 40, 1'b0);
    idle(3);
    do_load(1'b0, -1, 1'b1);

    for (int p = 0; p < 6; p++) begin
      idle($urandom_range(0, 3));
      do_read(1'($urandom_range(0, 1)), -1, 32'h0);
    end
    idle(4);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/full_st0_tap_ctrl.md
Name: full_st0_tap_ctrl

Overview:
Control stage that sits directly upstream of the stage-0 tap memory (6 lanes x 32 bit, 16 rows) and drives its tap_int_192_4 control bundle.
- LOAD: packs a serial 32-bit tap-word stream into per-lane sub-writes.
- READ: sequences full 192-bit row reads, either linear or interleaved (transposed), and flags returning data for the downstream MAC stage.
- Owns all row/lane counters; the tap memory stays purely address-driven.

Parameters:
LANES, 6, lanes per row (32-bit words per 192-bit row)
ROWS, 16, tap-memory rows used; ROWS <= 16
AW, 4, row address width
RD_LAT, 1, tap-memory read latency in cycles

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
start_load  input  1  pulse: begin LOAD of ROWS*LANES words
start_read  input  1  pulse: begin READ pass of ROWS rows
read_inter  input  1  sampled with start_read: 1 = interleaved pass
load_vld  input  1  load word valid
load_data  input  32  load word
load_ready  output  1  controller accepts load word this cycle
tap_int  output  tap_int_192_4  control bundle to tap memory (fields below)
tap_int_wr_data  output  192  full-row write data; always 0 in this block
tap_int_rd_data  input  192  row data returned by tap memory
row_vld  output  1  row_data valid (one-cycle qualifier)
row_data  output  192  registered copy of tap_int_rd_data
row_last  output  1  with row_vld: last row of the pass
busy  output  1  state != IDLE
done  output  1  one-cycle pulse when LOAD or READ completes

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; all counters 0.
  - All outputs 0, including every tap_int field.
  - Applies mid-operation too: any in-flight pass is abandoned and no done pulse is issued.
- States:
  - IDLE -> LOAD on start_load.
  - IDLE -> READ on start_read.
  - Both starts in the same cycle: LOAD wins; start_read is dropped.
  - start_* while not IDLE: ignored.
- LOAD:
  - load_ready=1 in LOAD only.
  - On each load_vld&load_ready beat, the same cycle drives:
    - sub_vld=1
    - sub_addr=lane
    - sub_data=load_data
    - wr_address=row
    - wr_vld=0
  - Then lane++. On lane==LANES-1: lane=0, row++.
  - Beat with row==ROWS-1 and lane==LANES-1: -> IDLE, done=1 next cycle.
  - Gaps in load_vld stall counters; no timeout.
- READ linear (read_inter=0):
  - One row per cycle: rd_vld=1, rd_address=row, inter=0, inter_first=0.
  - row 0..ROWS-1, then -> DRAIN.
- READ interleaved (read_inter=1):
  - Same rd_vld cadence, ROWS beats.
  - inter=1 on every beat; inter_first=1 on beat 0 only.
  - rd_address=row is still driven but is ignored by the tap memory except on beat 0.
  - Required sequence of the memory's internal counters: lane counter resets on inter_first and wraps every LANES beats; row base steps by LANES on each wrap.
- DRAIN:
  - Wait RD_LAT cycles for the final read, then -> IDLE with done=1.
- Return path:
  - Shift register of depth RD_LAT carrying rd_vld and last-beat flags.
  - row_vld/row_last/row_data are registered, so they lag the issuing beat by RD_LAT+1 cycles.
  - No backpressure: the consumer must accept every row_vld.
- Widths:
  - Row counter is AW bits; lane counter is 3 bits.
  - Row counter never exceeds ROWS-1; lane counter never exceeds LANES-1.
  - ROWS=16 requires the 4-bit row counter to reach 15 without overflow before exit.
- sub_vld and rd_vld are never asserted in the same cycle.

Decomposition:
- tap_int_192_4 already exists in the shared types package.
- Add to that package:
  - tap_ctrl_state_e enum: IDLE/LOAD/READ/DRAIN.
  - TAP_LANES=6 and TAP_ROWS=16 constants.
- One natural sub-module: full_st0_tap_rd_align, the RD_LAT-deep valid/last delay line plus the row_data register.

Test Plan:
- Reset with reset=0 held 3 cycles, then release -> busy=0, load_ready=0, all tap_int fields 0, row_vld=0.
- start_load, then 96 consecutive words 0x100+i -> sub_addr cycles 0..5, wr_address 0..15; done one cycle after beat 95. A subsequent linear read returns row r lane l = 0x100+6r+l.
- Linear READ (ROWS=16) -> 16 consecutive rd_vld beats, addr 0..15. row_vld on cycles 3..18 after start. row_last only with row 15. done once.
- Interleaved READ -> inter=1 for 16 beats, inter_first only on beat 0. Row data matches the transposed model: lane offset (k+l) mod 6 + 6*floor(k/6).
- start_load and start_read in the same cycle -> LOAD entered, no rd_vld. start_read during LOAD ignored.
- reset low at LOAD beat 40 -> immediate IDLE, no done. A fresh start_load then restarts at row 0, lane 0.
